// File: rtl/if_unit_if.sv
// Instruction-memory req/ack bus between the fetch stage (master) and instruction memory (slave).
// imem_addr is stable while imem_req is high; imem_ack is a one-cycle completion strobe.
interface if_unit_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        imem_ack;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_rdata,
    input  imem_ack
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_rdata,
    output imem_ack
  );
endinterface

// File: rtl/if_unit.sv
// Fetch stage: owns PC and IR, and fetches over a variable-latency req/ack bus with a timeout abort.
// The IR loads 1+ cycles after the fetch command, and fetch_busy asks the CU to hold while a request is outstanding.
module if_unit #(
  parameter logic [31:0] PC_RESET = 32'h0000_0000,
  parameter int          TIMEOUT  = 16,
  parameter logic [31:0] NOP_INSN = 32'h0000_0013
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              PC_Write,
  input  logic              IR_Write,
  if_unit_if.master         imem,
  output logic              fetch_busy,
  output logic              ir_valid,
  output logic              fetch_err,
  output logic [31:0]       pc,
  output logic [31:0]       ir,
  output logic [6:0]        opcode,
  output logic [2:0]        funct3,
  output logic [6:0]        funct7,
  output logic [4:0]        rs1,
  output logic [4:0]        rs2,
  output logic [4:0]        rd,
  output logic [31:0]       imm
);

  localparam int          CW       = $clog2(TIMEOUT);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);
  // Low PC bits are forced to zero even if PC_RESET is misaligned.
  localparam logic [31:0] PC_INIT  = {PC_RESET[31:2], 2'b00};

  typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic          adv;
  logic          req_q;

  assign imem.imem_req  = req_q;
  assign imem.imem_addr = pc;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      pc         <= PC_INIT;
      ir         <= NOP_INSN;
      req_q      <= 1'b0;
      fetch_busy <= 1'b0;
      ir_valid   <= 1'b0;
      fetch_err  <= 1'b0;
      cnt        <= '0;
      adv        <= 1'b0;
    end else begin
      ir_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (IR_Write) begin
            state      <= REQ;
            adv        <= PC_Write;
            fetch_err  <= 1'b0;
            cnt        <= '0;
            req_q      <= 1'b1;
            fetch_busy <= 1'b1;
          end else if (PC_Write) begin
            pc <= pc + 32'd4;
          end
        end
        REQ: begin
          // An ack in the expiry cycle still completes the fetch normally.
          if (imem.imem_ack) begin
            ir         <= imem.imem_rdata;
            if (adv) pc <= pc + 32'd4;
            state      <= DONE;
            req_q      <= 1'b0;
            fetch_busy <= 1'b0;
            ir_valid   <= 1'b1;
          end else if (cnt == CNT_LAST) begin
            ir         <= NOP_INSN;
            fetch_err  <= 1'b1;
            state      <= IDLE;
            req_q      <= 1'b0;
            fetch_busy <= 1'b0;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign opcode = ir[6:0];
  assign funct3 = ir[14:12];
  assign funct7 = ir[31:25];
  assign rs1    = ir[19:15];
  assign rs2    = ir[24:20];
  assign rd     = ir[11:7];

  always_comb begin
    imm = 32'd0;
    case (ir[6:0])
      7'b0010011: imm = {{20{ir[31]}}, ir[31:20]};
      7'b0110111: imm = {ir[31:12], 12'b0};
      default:    imm = 32'd0;
    endcase
  end

endmodule
